// File: rtl/branch_pkg.sv
// branch_pkg: shared definitions for the EX-stage branch resolve controller.
//   - RV32I conditional-branch funct3 encodings (BR_BEQ .. BR_BGEU)
//   - br_ctr_t : 2-bit saturating predictor counter
//   - br_cnt_t : performance counter word
//   - BHT_INIT : predictor reset value (weakly not-taken)
//   - helpers  : funct3 legality, taken evaluation, counter saturation
package branch_pkg;

  localparam int CNT_W = 32;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef logic [1:0]       br_ctr_t;
  typedef logic [CNT_W-1:0] br_cnt_t;

  localparam br_ctr_t BHT_INIT = 2'b01;

  // 010/011 are not branches; the decoder traps them, they never reach EX.
  function automatic logic br_legal(input logic [2:0] f3);
    return (f3[2:1] != 2'b01);
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic less,
                                    input logic equal);
    logic t;
    case (f3)
      BR_BEQ:           t = equal;
      BR_BNE:           t = ~equal;
      BR_BLT, BR_BLTU:  t = less;
      BR_BGE, BR_BGEU:  t = ~less;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic br_ctr_t ctr_next(input br_ctr_t c, input logic taken);
    br_ctr_t n;
    if (taken) n = (c == 2'b11) ? c : c + 2'd1;
    else       n = (c == 2'b00) ? c : c - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// bht_2bit: array of DEPTH 2-bit saturating branch predictor counters.
//   i_clk, i_rst_n        : clock, async active-low reset (all entries -> BHT_INIT)
//   i_rd_idx / o_rd_ctr   : combinational read port (fetch lookup)
//   i_upd_en / i_upd_idx  : update port, one entry per cycle
//   i_upd_taken           : resolved direction, counter saturates toward it
// A read and update of the same entry in one cycle returns the old value;
// there is deliberately no bypass.
module bht_2bit
  import branch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [IW-1:0] i_rd_idx,
  output logic [1:0]    o_rd_ctr,
  input  logic          i_upd_en,
  input  logic [IW-1:0] i_upd_idx,
  input  logic          i_upd_taken
);

  br_ctr_t ctr [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= BHT_INIT;
    end else if (i_upd_en) begin
      ctr[i_upd_idx] <= ctr_next(ctr[i_upd_idx], i_upd_taken);
    end
  end

  assign o_rd_ctr = ctr[i_rd_idx];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: EX-stage sequencing of the external branch comparator.
//   ID side : i_id_valid/i_id_is_br/i_id_funct3/i_id_pc/i_id_target/i_id_pred_taken
//   brc     : o_br_un (unsigned select) out, i_br_less/i_br_equal in
//   control : i_stall holds EX; o_redirect/o_redirect_pc/o_flush on mispredict
//   fetch   : i_if_pc lookup -> o_pred_taken
//   perf    : o_br_count (retired branches), o_mispred_count (retired mispredicts)
// Optional feature macro: BRANCH_BHT_EN adds a BHT_DEPTH-entry 2-bit predictor;
// without it o_pred_taken is tied 0 (static not-taken) and no BHT exists.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_id_valid,
  input  logic             i_id_is_br,
  input  logic [2:0]       i_id_funct3,
  input  logic [XLEN-1:0]  i_id_pc,
  input  logic [XLEN-1:0]  i_id_target,
  input  logic             i_id_pred_taken,
  input  logic [XLEN-1:0]  i_if_pc,
  output logic             o_pred_taken,
  output logic             o_br_un,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  output logic             o_redirect,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_flush,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_mispred_count
);

  logic            ex_valid;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred;

  logic taken, mispredict, retire;

  // EX capture; the ID slot is killed by this cycle's flush so a wrong-path
  // branch never reaches EX.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_valid  <= 1'b0;
      ex_funct3 <= '0;
      ex_pc     <= '0;
      ex_target <= '0;
      ex_pred   <= 1'b0;
    end else if (!i_stall) begin
      ex_valid  <= i_id_valid & i_id_is_br & ~o_flush & br_legal(i_id_funct3);
      ex_funct3 <= i_id_funct3;
      ex_pc     <= i_id_pc;
      ex_target <= i_id_target;
      ex_pred   <= i_id_pred_taken;
    end
  end

  assign o_br_un    = ex_funct3[1];
  assign taken      = br_taken(ex_funct3, i_br_less, i_br_equal);
  assign mispredict = ex_valid & (taken != ex_pred);
  assign retire     = ex_valid & ~i_stall;

  // Gating with !i_stall gives one redirect per branch: the branch leaves EX
  // on the same edge the redirect is taken.
  assign o_redirect    = mispredict & ~i_stall;
  assign o_flush       = o_redirect;
  assign o_redirect_pc = o_redirect ? (taken ? ex_target : ex_pc + XLEN'(4)) : '0;

  logic [CNT_W-1:0] br_cnt, mis_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (retire) begin
      br_cnt <= br_cnt + CNT_W'(1);
      if (mispredict) mis_cnt <= mis_cnt + CNT_W'(1);
    end
  end

  assign o_br_count      = br_cnt;
  assign o_mispred_count = mis_cnt;

`ifdef BRANCH_BHT_EN
  localparam int IW = $clog2(BHT_DEPTH);

  logic [1:0] rd_ctr;

  bht_2bit #(.DEPTH(BHT_DEPTH), .IW(IW)) u_bht (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rd_idx    (i_if_pc[IW+1:2]),
    .o_rd_ctr    (rd_ctr),
    .i_upd_en    (retire),
    .i_upd_idx   (ex_pc[IW+1:2]),
    .i_upd_taken (taken)
  );

  assign o_pred_taken = rd_ctr[1];

  logic unused_bht;
  assign unused_bht = ^{i_if_pc[XLEN-1:IW+2], i_if_pc[1:0], rd_ctr[0]};
`else
  assign o_pred_taken = 1'b0;

  logic unused_bht;
  assign unused_bht = (BHT_DEPTH > 0) ? ^i_if_pc : 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

`ifdef BRANCH_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_stall, i_id_valid, i_id_is_br, i_id_pred_taken;
  logic [2:0]  i_id_funct3;
  logic [31:0] i_id_pc, i_id_target, i_if_pc;
  logic        o_pred_taken, o_br_un, i_br_less, i_br_equal;
  logic        o_redirect, o_flush;
  logic [31:0] o_redirect_pc, o_br_count, o_mispred_count;
  logic [31:0] rs1, rs2;

  always #5 i_clk = ~i_clk;

  // Comparator stand-in driven by the DUT's unsigned select.
  assign i_br_equal = (rs1 == rs2);
  assign i_br_less  = o_br_un ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));

  branch_resolve_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall),
    .i_id_valid(i_id_valid), .i_id_is_br(i_id_is_br), .i_id_funct3(i_id_funct3),
    .i_id_pc(i_id_pc), .i_id_target(i_id_target), .i_id_pred_taken(i_id_pred_taken),
    .i_if_pc(i_if_pc), .o_pred_taken(o_pred_taken), .o_br_un(o_br_un),
    .i_br_less(i_br_less), .i_br_equal(i_br_equal), .o_redirect(o_redirect),
    .o_redirect_pc(o_redirect_pc), .o_flush(o_flush),
    .o_br_count(o_br_count), .o_mispred_count(o_mispred_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic pred);
    i_id_valid = v; i_id_is_br = v; i_id_funct3 = f3;
    i_id_pc = pc; i_id_target = tgt; i_id_pred_taken = pred;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #2;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  bit        mv, mpred;
  bit [2:0]  mf3;
  bit [31:0] mpc, mtgt, mbr, mmis;
  int        mbht [16];

  function automatic bit ref_taken(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return !($signed(a) < $signed(b));
      3'd6: return a < b;
      3'd7: return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    mv = 0; mbr = 0; mmis = 0;
    for (int i = 0; i < 16; i++) mbht[i] = 1;
  endtask

  task automatic model_step();
    bit t, mis, rd, pt;
    bit [31:0] rpc;
    int bi;
    t   = ref_taken(mf3, rs1, rs2);
    mis = mv && (t != mpred);
    rd  = mis && !i_stall;
    rpc = rd ? (t ? mtgt : mpc + 32'd4) : 32'd0;
    pt  = BHT_ON ? (mbht[(i_if_pc >> 2) % 16] >= 2) : 1'b0;
    chk("rnd_redirect", o_redirect, rd);
    chk("rnd_flush", o_flush, rd);
    chk("rnd_redirect_pc", o_redirect_pc, rpc);
    chk("rnd_pred_taken", o_pred_taken, pt);
    chk("rnd_br_count", o_br_count, mbr);
    chk("rnd_mispred_count", o_mispred_count, mmis);
    if (mv) chk("rnd_br_un", o_br_un, (mf3 == 3'd6 || mf3 == 3'd7));
    if (mv && !i_stall) begin
      mbr++;
      if (mis) mmis++;
      bi = (mpc >> 2) % 16;
      mbht[bi] = t ? ((mbht[bi] < 3) ? mbht[bi] + 1 : 3) : ((mbht[bi] > 0) ? mbht[bi] - 1 : 0);
    end
    if (!i_stall) begin
      mv = i_id_valid && i_id_is_br && !rd && !(i_id_funct3 == 3'd2 || i_id_funct3 == 3'd3);
      mf3 = i_id_funct3; mpc = i_id_pc; mtgt = i_id_target; mpred = i_id_pred_taken;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        idv;
    logic [2:0]  f3;
    logic [31:0] pc, tgt;
    logic        pred;
    logic [31:0] rs1, rs2;
    logic        redir;
    logic [31:0] rpc;
    logic        chk_un, un;
    logic [31:0] br, mis;
  } vec_t;

  vec_t tbl [9];

  logic [31:0] pcs [6];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    //            idv f3    pc            tgt           pd rs1           rs2           rd rpc          cu un br mis
    tbl[0] = '{1, 3'd0, 32'h100, 32'h140, 0, 32'd0,        32'd0,        0, 32'h0,   0, 0, 0, 0};
    tbl[1] = '{0, 3'd0, 32'h0,   32'h0,   0, 32'd100,      32'd100,      1, 32'h140, 1, 0, 0, 0};
    tbl[2] = '{1, 3'd6, 32'h200, 32'h300, 1, 32'd0,        32'd0,        0, 32'h0,   0, 0, 1, 1};
    tbl[3] = '{0, 3'd0, 32'h0,   32'h0,   0, 32'h80000000, 32'h7FFFFFFF, 1, 32'h204, 1, 1, 1, 1};
    tbl[4] = '{1, 3'd4, 32'h300, 32'h380, 1, 32'd0,        32'd0,        0, 32'h0,   0, 0, 2, 2};
    tbl[5] = '{0, 3'd0, 32'h0,   32'h0,   0, 32'h80000000, 32'd1,        0, 32'h0,   1, 0, 2, 2};
    tbl[6] = '{1, 3'd2, 32'h800, 32'h880, 1, 32'd0,        32'd0,        0, 32'h0,   0, 0, 3, 2};
    tbl[7] = '{0, 3'd0, 32'h0,   32'h0,   0, 32'd1,        32'd2,        0, 32'h0,   0, 0, 3, 2};
    tbl[8] = '{0, 3'd0, 32'h0,   32'h0,   0, 32'd0,        32'd0,        0, 32'h0,   0, 0, 3, 2};

    i_stall = 0; set_id(0, 3'd0, 32'h0, 32'h0, 0); i_if_pc = 32'h0; rs1 = 0; rs2 = 0;
    i_rst_n = 1'b0;
    #3;
    chk("reset_redirect", o_redirect, 0);
    chk("reset_flush", o_flush, 0);
    chk("reset_redirect_pc", o_redirect_pc, 0);
    chk("reset_br_count", o_br_count, 0);
    chk("reset_mispred_count", o_mispred_count, 0);
    chk("reset_pred_taken", o_pred_taken, 0);
    chk("reset_br_un", o_br_un, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // tests 1-3 plus illegal funct3
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      set_id(tbl[i].idv, tbl[i].f3, tbl[i].pc, tbl[i].tgt, tbl[i].pred);
      rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
      #2;
      chk($sformatf("tbl%0d_redirect", i), o_redirect, tbl[i].redir);
      chk($sformatf("tbl%0d_flush", i), o_flush, tbl[i].redir);
      chk($sformatf("tbl%0d_redirect_pc", i), o_redirect_pc, tbl[i].rpc);
      chk($sformatf("tbl%0d_br_count", i), o_br_count, tbl[i].br);
      chk($sformatf("tbl%0d_mispred_count", i), o_mispred_count, tbl[i].mis);
      if (tbl[i].chk_un) chk($sformatf("tbl%0d_br_un", i), o_br_un, tbl[i].un);
    end

    // test 4: BNE mispredict held by stall
    next_cycle(); set_id(1, 3'd1, 32'h400, 32'h480, 0); rs1 = 1; rs2 = 2;
    for (int k = 0; k < 3; k++) begin
      next_cycle(); set_id(0, 3'd0, 0, 0, 0); i_stall = 1; #2;
      chk("stall_redirect", o_redirect, 0);
      chk("stall_br_count", o_br_count, 3);
    end
    next_cycle(); i_stall = 0; #2;
    chk("release_redirect", o_redirect, 1);
    chk("release_redirect_pc", o_redirect_pc, 32'h480);
    next_cycle(); #2;
    chk("after_release_redirect", o_redirect, 0);
    chk("after_release_br_count", o_br_count, 4);
    chk("after_release_mispred", o_mispred_count, 3);

    // test 5: back-to-back, first mispredicts at top-of-memory
    next_cycle(); set_id(1, 3'd0, 32'hFFFFFFFC, 32'h40, 1); rs1 = 1; rs2 = 2;
    next_cycle(); set_id(1, 3'd0, 32'h600, 32'h640, 0); #2;
    chk("wrap_redirect", o_redirect, 1);
    chk("wrap_redirect_pc", o_redirect_pc, 32'h0);
    next_cycle(); set_id(0, 3'd0, 0, 0, 0); rs1 = 5; rs2 = 5; #2;
    chk("flushed_id_redirect", o_redirect, 0);
    chk("flushed_br_count", o_br_count, 5);
    next_cycle(); #2;
    chk("flushed_never_retires", o_br_count, 5);
    chk("flushed_mispred", o_mispred_count, 4);

    // reset in the middle of a mispredicting branch
    next_cycle(); set_id(1, 3'd1, 32'h700, 32'h780, 0);
    next_cycle(); set_id(0, 3'd0, 0, 0, 0); rs1 = 1; rs2 = 2; i_rst_n = 0; #1;
    chk("midrst_redirect", o_redirect, 0);
    chk("midrst_redirect_pc", o_redirect_pc, 0);
    chk("midrst_br_count", o_br_count, 0);
    chk("midrst_mispred", o_mispred_count, 0);
    @(negedge i_clk); i_rst_n = 1;
    next_cycle(); #2;
    chk("post_rst_redirect", o_redirect, 0);
    chk("post_rst_br_count", o_br_count, 0);

    // test 6: predictor training on one pc
    i_if_pc = 32'h500;
    for (int k = 0; k < 3; k++) begin
      next_cycle(); set_id(1, 3'd0, 32'h500, 32'h540, 1);
      next_cycle(); set_id(0, 3'd0, 0, 0, 0); rs1 = 7; rs2 = 7; #2;
      chk($sformatf("bht_train%0d_pred", k), o_pred_taken, BHT_ON && k >= 1);
      chk($sformatf("bht_train%0d_redirect", k), o_redirect, 0);
    end
    next_cycle(); #2;
    chk("bht_sat_pred", o_pred_taken, BHT_ON);
    next_cycle(); set_id(1, 3'd0, 32'h500, 32'h540, 1);
    next_cycle(); set_id(0, 3'd0, 0, 0, 0); rs1 = 1; rs2 = 2; #2;
    chk("bht_nt_redirect_pc", o_redirect_pc, 32'h504);
    next_cycle(); #2;
    chk("bht_after_nt_pred", o_pred_taken, BHT_ON);
    i_rst_n = 0; #1;
    chk("bht_rst_pred", o_pred_taken, 0);
    chk("bht_rst_br_count", o_br_count, 0);
    @(negedge i_clk); i_rst_n = 1;

    // randomized phase against the reference model
    model_reset();
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    pcs[3] = 32'h140; pcs[4] = 32'hFFFFFFFC; pcs[5] = 32'h200;
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      i_stall         = ($urandom_range(3) == 0);
      i_id_valid      = ($urandom_range(4) != 0);
      i_id_is_br      = ($urandom_range(4) != 0);
      i_id_funct3     = 3'($urandom_range(7));
      i_id_pc         = pcs[$urandom_range(5)];
      i_id_target     = $urandom & 32'hFFFFFFFC;
      i_id_pred_taken = 1'($urandom_range(1));
      i_if_pc         = pcs[$urandom_range(5)];
      rs1             = ($urandom_range(1) == 0) ? 32'h80000000 ^ $urandom_range(3) : $urandom;
      rs2             = ($urandom_range(2) == 0) ? rs1 : (($urandom_range(1) == 0) ? 32'($urandom_range(3)) : $urandom);
      #2;
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
